date_edit_ctrl: RTL

Sequencing controller for the RTC date-setting path: turns the user's mode/next/up/down buttons into the 2-bit field-select code `EN` and single-cycle `aumento`/`disminuye` pulses that drive the day, month and year counters. It adds auto-repeat on held buttons, an inactivity timeout, and a blink strobe for the display of the field being edited. It sits between the button debouncers and the date counter bank.

---
 rtl/date_edit_ctrl_pkg.sv | 47 ++++
 rtl/date_edit_ctrl_if.sv | 24 ++
 rtl/date_edit_ctrl_btn_repeat.sv | 55 +++++
 rtl/date_edit_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/date_edit_ctrl_pkg.sv
// Shared field codes, FSM states and default timing for the
// RTC date-edit controller.
package date_ctrl_pkg;

  localparam logic [1:0] F_NONE  = 2'd0;
  localparam logic [1:0] F_MONTH = 2'd1;
  localparam logic [1:0] F_YEAR  = 2'd2;
  localparam logic [1:0] F_DAY   = 2'd3;

  localparam int DEF_TIMEOUT = 1000;
  localparam int DEF_DELAY   = 50;
  localparam int DEF_RATE    = 10;
  localparam int DEF_BLINK   = 25;

  typedef enum logic [1:0] {
    IDLE,
    ED_DAY,
    ED_MONTH,
    ED_YEAR
  } state_t;

  function automatic logic [1:0] field_of(state_t s);
    logic [1:0] f;
    f = F_NONE;
    unique case (s)
      IDLE:     f = F_NONE;
      ED_DAY:   f = F_DAY;
      ED_MONTH: f = F_MONTH;
      ED_YEAR:  f = F_YEAR;
      default:  f = F_NONE;
    endcase
    return f;
  endfunction

  function automatic state_t next_field(state_t s);
    state_t n;
    n = s;
    unique case (s)
      ED_DAY:   n = ED_MONTH;
      ED_MONTH: n = ED_YEAR;
      ED_YEAR:  n = ED_DAY;
      default:  n = s;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/date_edit_ctrl_if.sv
// Button/timebase inputs and field-select/pulse outputs of the
// date-edit controller.
interface date_edit_ctrl_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_next;
  logic       btn_up;
  logic       btn_down;
  logic [1:0] EN;
  logic       aumento;
  logic       disminuye;
  logic       editing;
  logic       blink;

  modport master (
    output tick, btn_mode, btn_next, btn_up, btn_down,
    input  EN, aumento, disminuye, editing, blink
  );

  modport slave (
    input  tick, btn_mode, btn_next, btn_up, btn_down,
    output EN, aumento, disminuye, editing, blink
  );
endinterface

// File: rtl/date_edit_ctrl_btn_repeat.sv
// Edge detect plus hold-to-repeat for one up/down button.
// rise and rep are unregistered requests; the top registers them.
module btn_repeat
  import date_ctrl_pkg::*;
#(
  parameter int REPEAT_DELAY = DEF_DELAY,
  parameter int REPEAT_RATE  = DEF_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  input  logic enable,
  input  logic clear,
  output logic level,
  output logic rise,
  output logic rep
);

  logic        s;
  logic        p;
  logic        run;
  logic        active;
  logic [15:0] cnt;
  logic [15:0] lim;

  assign level  = s;
  assign rise   = s & ~p;
  // the edge cycle itself never counts toward the hold time
  assign active = enable & ~clear & s & ~rise;
  assign lim    = run ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY);
  assign rep    = active & tick & (cnt + 16'd1 == lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s   <= 1'b0;
      p   <= 1'b0;
      cnt <= '0;
      run <= 1'b0;
    end else begin
      s <= btn;
      p <= s;
      if (!active) begin
        cnt <= '0;
        run <= 1'b0;
      end else if (rep) begin
        cnt <= '0;
        run <= 1'b1;
      end else if (tick) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/date_edit_ctrl.sv
// Date-edit sequencer: field-select FSM, inc/dec pulses with
// auto-repeat, inactivity timeout and blink strobe.
module date_edit_ctrl
  import date_ctrl_pkg::*;
#(
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT,
  parameter int REPEAT_DELAY  = DEF_DELAY,
  parameter int REPEAT_RATE   = DEF_RATE,
  parameter int BLINK_TICKS   = DEF_BLINK
) (
  input logic             clk,
  input logic             rst,
  date_edit_ctrl_if.slave bus
);

  state_t      state, state_d;
  logic        ms, mp, ns, np;
  logic        mode_e, next_e, edit;
  logic        up_lvl, up_rise, up_rep;
  logic        dn_lvl, dn_rise, dn_rep;
  logic        both, rclr, any_evt;
  logic        up_req, dn_req;
  logic [15:0] tcnt, tcnt_d;
  logic [15:0] bcnt, bcnt_d;
  logic        blink_q, blink_d;
  logic [1:0]  en_q;
  logic        inc_q, dec_q, edit_q;

  assign mode_e = ms & ~mp;
  assign next_e = ns & ~np;
  assign edit   = (state != IDLE);
  assign both   = up_lvl & dn_lvl;
  assign rclr   = ~edit | mode_e | next_e | both;

  btn_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_up (
    .clk(clk), .rst(rst), .tick(bus.tick),
    .btn(bus.btn_up), .enable(edit), .clear(rclr),
    .level(up_lvl), .rise(up_rise), .rep(up_rep)
  );

  btn_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_dn (
    .clk(clk), .rst(rst), .tick(bus.tick),
    .btn(bus.btn_down), .enable(edit), .clear(rclr),
    .level(dn_lvl), .rise(dn_rise), .rep(dn_rep)
  );

  // mode and next outrank up/down in the same cycle
  assign up_req = edit & ~mode_e & ~next_e & ~both
                & (up_rise | up_rep);
  assign dn_req = edit & ~mode_e & ~next_e & ~both
                & (dn_rise | dn_rep);
  assign any_evt = mode_e | next_e | up_rise | dn_rise
                 | up_rep | dn_rep;

  always_comb begin
    state_d = state;
    tcnt_d  = tcnt;
    bcnt_d  = bcnt;
    blink_d = blink_q;
    if (!edit || mode_e || next_e) begin
      tcnt_d  = '0;
      bcnt_d  = '0;
      blink_d = 1'b0;
      if (!edit && mode_e)
        state_d = ED_DAY;
      else if (edit && mode_e)
        state_d = IDLE;
      else if (edit)
        state_d = next_field(state);
    end else begin
      if (any_evt)
        tcnt_d = '0;
      else if (bus.tick) begin
        if (tcnt + 16'd1 == 16'(TIMEOUT_TICKS)) begin
          state_d = IDLE;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt + 16'd1;
        end
      end
      if (state_d == IDLE) begin
        bcnt_d  = '0;
        blink_d = 1'b0;
      end else if (bus.tick) begin
        if (bcnt + 16'd1 == 16'(BLINK_TICKS)) begin
          bcnt_d  = '0;
          blink_d = ~blink_q;
        end else begin
          bcnt_d = bcnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ms      <= 1'b0;
      mp      <= 1'b0;
      ns      <= 1'b0;
      np      <= 1'b0;
      tcnt    <= '0;
      bcnt    <= '0;
      blink_q <= 1'b0;
      en_q    <= F_NONE;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      edit_q  <= 1'b0;
    end else begin
      state   <= state_d;
      ms      <= bus.btn_mode;
      mp      <= ms;
      ns      <= bus.btn_next;
      np      <= ns;
      tcnt    <= tcnt_d;
      bcnt    <= bcnt_d;
      blink_q <= blink_d;
      en_q    <= field_of(state_d);
      inc_q   <= up_req;
      dec_q   <= dn_req;
      edit_q  <= (state_d != IDLE);
    end
  end

  assign bus.EN        = en_q;
  assign bus.aumento   = inc_q;
  assign bus.disminuye = dec_q;
  assign bus.editing   = edit_q;
  assign bus.blink     = blink_q;

endmodule
